// File: rtl/muldiv_issue_ctrl.sv
// Issue/sequencing controller for the shared multi-cycle mul/div unit.
// Latches one request, pulses start, waits for result or timeout, hands off to writeback.
module muldiv_issue_ctrl #(
  parameter int TIMEOUT          = 40,
  parameter int EXC_RD           = 30,
  parameter int EXC_CODE_DIV     = 5,
  parameter int EXC_CODE_TIMEOUT = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_div,
  input  logic [31:0] req_opA,
  input  logic [31:0] req_opB,
  input  logic [4:0]  req_rd,
  input  logic        flush,
  output logic [31:0] unit_opA,
  output logic [31:0] unit_opB,
  output logic        unit_ctrl_MULT,
  output logic        unit_ctrl_DIV,
  input  logic [31:0] unit_result,
  input  logic        unit_exception,
  input  logic        unit_resultRDY,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        busy,
  input  logic [4:0]  chk_rs,
  input  logic [4:0]  chk_rt,
  output logic        hazard
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]    r_state;
  logic [31:0]   r_opA;
  logic [31:0]   r_opB;
  logic [4:0]    r_rd;
  logic          r_is_div;
  logic [CW-1:0] r_cnt;
  logic          r_timeout;
  logic [31:0]   r_result;
  logic          r_exc;

  logic w_rdy_ok;
  logic w_tmo;
  logic w_done;
  logic w_start;
  logic w_excp;

  // Ready in the first WAIT cycle may be left over from the previous op.
  assign w_rdy_ok = unit_resultRDY && (r_cnt != '0);
  assign w_tmo    = (r_cnt == CNT_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_opA     <= '0;
      r_opB     <= '0;
      r_rd      <= '0;
      r_is_div  <= 1'b0;
      r_cnt     <= '0;
      r_timeout <= 1'b0;
      r_result  <= '0;
      r_exc     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_opA     <= req_opA;
            r_opB     <= req_opB;
            r_rd      <= req_rd;
            r_is_div  <= req_is_div;
            r_timeout <= 1'b0;
            r_exc     <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= flush ? S_DRAIN : S_WAIT;
        end
        S_WAIT: begin
          if (flush) begin
            r_state <= S_DRAIN;
          end else if (w_rdy_ok) begin
            r_result <= unit_result;
            r_exc    <= unit_exception;
            // A normal result to x0 has nothing to write back.
            if (!unit_exception && r_rd == 5'd0)
              r_state <= S_IDLE;
            else
              r_state <= S_DONE;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          if (flush || wb_ready)
            r_state <= S_IDLE;
        end
        S_DRAIN: begin
          if (w_rdy_ok || w_tmo)
            r_state <= S_IDLE;
          else
            r_cnt <= r_cnt + 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_done  = (r_state == S_DONE);
  assign w_start = (r_state == S_START);
  assign w_excp  = r_timeout | r_exc;

  assign req_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign unit_opA       = r_opA;
  assign unit_opB       = r_opB;
  assign unit_ctrl_MULT = w_start & ~r_is_div;
  assign unit_ctrl_DIV  = w_start & r_is_div;

  always_comb begin
    wb_valid     = 1'b0;
    wb_rd        = '0;
    wb_data      = '0;
    wb_exception = 1'b0;
    if (w_done) begin
      wb_valid     = 1'b1;
      wb_exception = w_excp;
      if (r_timeout) begin
        wb_rd   = 5'(EXC_RD);
        wb_data = 32'(EXC_CODE_TIMEOUT);
      end else if (r_exc) begin
        wb_rd   = 5'(EXC_RD);
        wb_data = 32'(EXC_CODE_DIV);
      end else begin
        wb_rd   = r_rd;
        wb_data = r_result;
      end
    end
  end

  assign hazard = busy && (r_rd != 5'd0)
               && (chk_rs == r_rd || chk_rt == r_rd)
               && (r_state != S_DRAIN);

endmodule

// File: doc/muldiv_issue_ctrl.md
Name: muldiv_issue_ctrl

Overview:
Issue/sequencing controller for the shared 32-bit multi-cycle multiply/divide unit. It accepts one mult/div request from the execute stage and holds its operands stable. It pulses the unit's start control for one cycle, then waits for result-ready or a timeout. The result, or an exception code, is presented to writeback with a valid/ready handshake, and the controller raises a register hazard for dependent instructions while the operation is in flight.

Parameters:
TIMEOUT, 40, max WAIT cycles before declaring a timeout
EXC_RD, 30, destination register written on exception (status register)
EXC_CODE_DIV, 5, wb_data value on divide-by-zero
EXC_CODE_TIMEOUT, 6, wb_data value on timeout

Ports:
clock  in  1  system clock; all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  execute stage presents a mult/div op
req_ready  out  1  controller can accept (IDLE only)
req_is_div  in  1  1=divide, 0=multiply
req_opA  in  32  operand A (multiplier/dividend)
req_opB  in  32  operand B (multiplicand/divisor)
req_rd  in  5  destination register
flush  in  1  cancel in-flight op (branch/exception squash)
unit_opA  out  32  registered operand A to unit
unit_opB  out  32  registered operand B to unit
unit_ctrl_MULT  out  1  one-cycle multiply start pulse
unit_ctrl_DIV  out  1  one-cycle divide start pulse
unit_result  in  32  unit result
unit_exception  in  1  unit exception (divide by zero)
unit_resultRDY  in  1  unit result valid
wb_valid  out  1  writeback data valid
wb_ready  in  1  writeback accepts
wb_rd  out  5  writeback register
wb_data  out  32  writeback value
wb_exception  out  1  writeback carries an exception
busy  out  1  state != IDLE
chk_rs  in  5  source register 1 of the instruction in decode
chk_rt  in  5  source register 2 of the instruction in decode
hazard  out  1  decode must stall

Behaviour:
- States: IDLE, START, WAIT, DONE, DRAIN. Reset -> IDLE. All outputs 0 except req_ready=1. Operand/rd/op registers clear to 0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch opA, opB, rd, is_div; clear timeout flag; -> START.
  - flush in IDLE has no effect.
- START (exactly 1 cycle):
  - Drive unit_ctrl_DIV=is_div_q or unit_ctrl_MULT=~is_div_q; never both.
  - cnt<=0; -> WAIT.
  - If flush is asserted in START: the pulse still issues and the state goes to DRAIN.
- WAIT:
  - cnt increments each cycle.
  - unit_resultRDY is ignored while cnt==0, because ready may be stale from the previous op.
  - When ready and cnt>=1: capture result and exception -> DONE.
  - When cnt==TIMEOUT-1 without ready: set timeout flag -> DONE.
  - flush -> DRAIN, keeping cnt.
- DONE:
  - wb_valid=1, held with stable outputs until wb_ready; then -> IDLE. The handshake completes in the same cycle wb_ready is seen.
  - Normal result: wb_rd=rd_q, wb_data=result, wb_exception=0.
  - Divide exception: wb_rd=EXC_RD, wb_data=EXC_CODE_DIV, wb_exception=1.
  - Timeout: wb_rd=EXC_RD, wb_data=EXC_CODE_TIMEOUT, wb_exception=1.
  - Normal result with rd_q==0: skip wb_valid and go to IDLE directly.
  - flush in DONE: drop the result, -> IDLE.
- DRAIN:
  - The unit cannot abort, so the controller waits for ready (cnt>=1) or timeout with no writeback, then -> IDLE.
  - req_ready=0.
- unit_opA/unit_opB are driven from the latched registers in every state, so they stay stable from START until the op completes.
- hazard = busy & (rd_q!=0) & (chk_rs==rd_q | chk_rt==rd_q) & state!=DRAIN.
- busy=1 in START/WAIT/DONE/DRAIN.
- A new request is accepted only in IDLE. There is no back-to-back overlap; the minimum issue-to-issue interval is START+WAIT+DONE.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs cleared. Any unit_resultRDY arriving afterward is ignored in IDLE.

Test Plan:
1. Multiply: req opA=7, opB=-3, rd=8. Expect:
   - unit_ctrl_MULT high exactly 1 cycle after acceptance; unit_ctrl_DIV stays 0.
   - Unit model ready after 33 cycles.
   - wb_valid with wb_rd=8, wb_data=0xFFFFFFEB, wb_exception=0.
   - Returns to IDLE the cycle after wb_ready.
2. Divide by zero: opA=100, opB=0, rd=4, is_div=1; unit_exception=1 with ready. Expect wb_rd=30, wb_data=5, wb_exception=1.
3. Hazard: during WAIT for rd=8, chk_rs=8 -> hazard=1; chk_rs=9, chk_rt=0 -> hazard=0. With rd=0 the hazard never asserts, and no wb_valid is produced after completion.
4. Timeout/stale ready:
   - Hold unit_resultRDY=1 permanently. The cnt==0 cycle is ignored and completion occurs at cnt=1.
   - Hold unit_resultRDY=0. After TIMEOUT cycles: wb_data=6, wb_rd=30, wb_exception=1.
5. Flush: flush asserted in WAIT at cnt=5 -> state DRAIN, req_ready=0, no wb_valid. Ready arrives -> IDLE; the next request is accepted normally.
6. Backpressure/reset:
   - Hold wb_ready=0 for 10 cycles in DONE: wb_* stay stable, req_ready stays 0.
   - Assert reset mid-WAIT: outputs clear asynchronously and req_ready=1 after release.
